// File: rtl/trng_vn_sampler.sv
// trng_vn_sampler: synchronizes a free-running ring-oscillator tap, samples it
// at a programmable rate, applies von Neumann debiasing, packs the debiased
// bits MSB-first into words and offers them on a valid/ready interface.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_vn_sampler #(
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned DIV_W     = 8,
   parameter int unsigned REP_LIMIT = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              raw_i,
   input  logic [DIV_W-1:0]  div_i,
   output logic [WORD_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              dropped_o,
   output logic              health_fail_o
);

   localparam int unsigned CW = $clog2(WORD_W);

   typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

   state_t              state_q, state_d;
   logic                s1_q, samp_q;
   logic [DIV_W-1:0]    cnt_q;
   logic                strobe;
   logic                latch_a, emit, sample_stb, hold;
   logic                a_q;
   logic [WORD_W-1:0]   acc_q, acc_nxt;
   logic [CW-1:0]       bcnt_q;
   logic [WORD_W-1:0]   data_q;
   logic                valid_q, dropped_q;

   assign strobe     = enable_i && (cnt_q == div_i);
   assign sample_stb = strobe && ((state_q == FIRST) || (state_q == SECOND));
   assign acc_nxt    = {acc_q[WORD_W-2:0], a_q};

   // Two-flop synchronizer for the asynchronous oscillator tap
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q   <= 1'b0;
         samp_q <= 1'b0;
      end else begin
         s1_q   <= raw_i;
         samp_q <= s1_q;
      end
   end

   // Sample-period divider; a reduced div_i below cnt lets cnt wrap naturally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       cnt_q <= '0;
      else if (!enable_i) cnt_q <= '0;
      else if (strobe)   cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
   end

   // Pair FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Pair FSM next state, first-sample latch and debiased-bit emission
   always_comb begin
      state_d = state_q;
      latch_a = 1'b0;
      emit    = 1'b0;
      if (!enable_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:   state_d = FIRST;
            FIRST:  if (strobe) begin
                       latch_a = 1'b1;
                       state_d = SECOND;
                    end
            SECOND: if (strobe) begin
                       emit    = (a_q != samp_q) && !hold;
                       state_d = FIRST;
                    end
            default: state_d = IDLE;
         endcase
      end
   end

   // Accumulator, bit count and output word register with handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q       <= 1'b0;
         acc_q     <= '0;
         bcnt_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         dropped_q <= 1'b0;
         if (valid_q && ready_i) valid_q <= 1'b0;
         if (!enable_i) begin
            a_q    <= 1'b0;
            acc_q  <= '0;
            bcnt_q <= '0;
         end else begin
            if (latch_a) a_q <= samp_q;
            if (emit) begin
               if (bcnt_q == CW'(WORD_W - 1)) begin
                  acc_q  <= '0;
                  bcnt_q <= '0;
                  if (!valid_q || ready_i) begin
                     data_q  <= acc_nxt;
                     valid_q <= 1'b1;
                  end else begin
                     dropped_q <= 1'b1;
                  end
               end else begin
                  acc_q  <= acc_nxt;
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
         end
      end
   end

`ifdef TRNG_HEALTH_EN
   localparam int unsigned RW = $clog2(REP_LIMIT + 1);

   logic [RW-1:0] rep_q, rep_nxt;
   logic          last_q, fail_q;

   assign rep_nxt = ((rep_q == '0) || (samp_q != last_q)) ? RW'(1) : rep_q + 1'b1;
   assign hold    = fail_q;

   // Repetition-count health test over every strobed sample; sticky until disable
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rep_q  <= '0;
         last_q <= 1'b0;
         fail_q <= 1'b0;
      end else if (!enable_i) begin
         rep_q  <= '0;
         last_q <= 1'b0;
         fail_q <= 1'b0;
      end else if (sample_stb && !fail_q) begin
         rep_q  <= rep_nxt;
         last_q <= samp_q;
         if (rep_nxt >= RW'(REP_LIMIT)) fail_q <= 1'b1;
      end
   end

   assign health_fail_o = fail_q;
`else
   assign hold          = 1'b0;
   assign health_fail_o = 1'b0;
`endif

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign dropped_o = dropped_q;

endmodule

// File: tb/tb_trng_vn_sampler.sv
// Directed bench for trng_vn_sampler: table of streaming scenarios plus
// hand-written sequences for backpressure, disable, health and async reset.
module tb_trng_vn_sampler;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        enable_i;
   logic        raw_i;
   logic [7:0]  div_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        dropped_o;
   logic        health_fail_o;

   trng_vn_sampler #(.WORD_W(32), .DIV_W(8), .REP_LIMIT(32)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .raw_i         (raw_i),
      .div_i         (div_i),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .dropped_o     (dropped_o),
      .health_fail_o (health_fail_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic        stream [0:299];
   int          period = 1;
   logic        vhist  [0:299];
   logic [31:0] dhist  [0:299];
   logic        drhist [0:299];
   logic        hhist  [0:299];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Stream patterns: raw bit k/period is applied at posedge k of a run
   task automatic fill(input int pat);
      for (int i = 0; i < 300; i++) stream[i] = 1'b0;
      case (pat)
         0: for (int i = 0; i < 64; i++) begin
               stream[2*i]   = (i < 32);
               stream[2*i+1] = (i >= 32);
            end
         1: for (int g = 0; g < 16; g++) begin
               stream[8*g+0] = 1'b1; stream[8*g+1] = 1'b0;
               stream[8*g+2] = 1'b1; stream[8*g+3] = 1'b1;
               stream[8*g+4] = 1'b0; stream[8*g+5] = 1'b1;
               stream[8*g+6] = 1'b0; stream[8*g+7] = 1'b0;
            end
         2: for (int i = 0; i < 32; i++) begin
               stream[2*i]   = 1'b1;
               stream[2*i+1] = 1'b0;
            end
         3: for (int i = 0; i < 300; i++) stream[i] = 1'b1;
         4: for (int i = 0; i < 42; i++) begin
               stream[2*i]   = (i >= 32);
               stream[2*i+1] = (i < 32);
            end
         5: for (int i = 0; i < 32; i++) begin
               stream[2*i]   = (i % 2 == 0);
               stream[2*i+1] = (i % 2 != 0);
            end
         default: ;
      endcase
   endtask

   // Enable from idle and stream ncyc cycles, recording outputs after each posedge
   task automatic run(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk_i);
         raw_i = stream[k / period];
         if (k == 1) enable_i = 1'b1;
         @(posedge clk_i);
         #1;
         vhist[k]  = valid_o;
         dhist[k]  = data_o;
         drhist[k] = dropped_o;
         hhist[k]  = health_fail_o;
      end
   endtask

   task automatic idle();
      @(negedge clk_i);
      enable_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   typedef struct {
      string       name;
      int          pat;
      logic [7:0]  div;
      int          ncyc;
      int          at;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [0:3];

   initial begin
      int n;

      tbl[0] = '{name:"ones_div0",   pat:0, div:8'd0, ncyc:140, at:65,  exp_data:32'hFFFF_FFFF};
      tbl[1] = '{name:"zeros_div0",  pat:0, div:8'd0, ncyc:140, at:129, exp_data:32'h0000_0000};
      tbl[2] = '{name:"alt_discard", pat:1, div:8'd0, ncyc:140, at:127, exp_data:32'hAAAA_AAAA};
      tbl[3] = '{name:"ones_div3",   pat:2, div:8'd3, ncyc:270, at:256, exp_data:32'hFFFF_FFFF};

      rst_ni = 1'b0; enable_i = 1'b0; raw_i = 1'b0; div_i = '0; ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_valid",   {31'd0, valid_o},       32'd0);
      chk("reset_data",    data_o,                 32'd0);
      chk("reset_dropped", {31'd0, dropped_o},     32'd0);
      chk("reset_health",  {31'd0, health_fail_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Table-driven streaming scenarios with ready held high
      for (int t = 0; t < 4; t++) begin
         idle();
         ready_i = 1'b1;
         div_i   = tbl[t].div;
         period  = tbl[t].div + 1;
         fill(tbl[t].pat);
         run(tbl[t].ncyc);
         chk({tbl[t].name, "_pre"},   {31'd0, vhist[tbl[t].at - 1]}, 32'd0);
         chk({tbl[t].name, "_valid"}, {31'd0, vhist[tbl[t].at]},     32'd1);
         chk({tbl[t].name, "_data"},  dhist[tbl[t].at],              tbl[t].exp_data);
      end
      div_i = '0; period = 1;

      // Backpressure: second completed word is dropped, first word retained
      idle();
      ready_i = 1'b0;
      fill(0);
      run(140);
      n = 0;
      for (int k = 0; k < 140; k++) if (drhist[k]) n++;
      chk("bp_drop_count", n,                       1);
      chk("bp_drop_at",    {31'd0, drhist[129]},    32'd1);
      chk("bp_drop_after", {31'd0, drhist[130]},    32'd0);
      chk("bp_valid",      {31'd0, vhist[129]},     32'd1);
      chk("bp_data_kept",  dhist[129],              32'hFFFF_FFFF);
      @(negedge clk_i);
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("bp_handshake",  {31'd0, valid_o},        32'd0);

      // Disable mid-word with a pending word, then re-enable for fresh bits
      idle();
      ready_i = 1'b0;
      fill(4);
      run(86);
      chk("dis_rise_pre",  {31'd0, vhist[64]}, 32'd0);
      chk("dis_rise",      {31'd0, vhist[65]}, 32'd1);
      idle();
      chk("dis_pending",   {31'd0, valid_o},   32'd1);
      chk("dis_data",      data_o,             32'h0000_0000);
      ready_i = 1'b1;
      fill(5);
      run(80);
      chk("reen_consumed", {31'd0, vhist[0]},  32'd0);
      chk("reen_pre",      {31'd0, vhist[64]}, 32'd0);
      chk("reen_valid",    {31'd0, vhist[65]}, 32'd1);
      chk("reen_data",     dhist[65],          32'hAAAA_AAAA);

      // Stuck oscillator
      idle();
      ready_i = 1'b1;
      fill(3);
      run(80);
      n = 0;
      for (int k = 0; k < 80; k++) if (vhist[k]) n++;
      chk("stuck_no_valid", n, 0);
`ifdef TRNG_HEALTH_EN
      chk("health_pre",   {31'd0, hhist[32]}, 32'd0);
      chk("health_trip",  {31'd0, hhist[33]}, 32'd1);
      chk("health_hold",  {31'd0, hhist[79]}, 32'd1);
`else
      chk("health_off",   {31'd0, hhist[79]}, 32'd0);
`endif
      idle();
      chk("health_clear", {31'd0, health_fail_o}, 32'd0);

      // Asynchronous reset between clock edges with a word pending
      ready_i = 1'b0;
      fill(0);
      run(70);
      chk("arst_pending", {31'd0, vhist[69]}, 32'd1);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid",   {31'd0, valid_o},       32'd0);
      chk("arst_data",    data_o,                 32'd0);
      chk("arst_dropped", {31'd0, dropped_o},     32'd0);
      chk("arst_health",  {31'd0, health_fail_o}, 32'd0);
      @(negedge clk_i);
      enable_i = 1'b0;
      rst_ni   = 1'b1;
      repeat (2) @(posedge clk_i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trng_vn_sampler.md
Name: trng_vn_sampler

Overview:
Downstream consumer of the TRNG ring-oscillator inverter chain. It synchronizes the free-running raw oscillator tap and samples it at a programmable rate. It applies von Neumann debiasing, packs the debiased bits into words, and presents each word on a valid/ready interface to the entropy FIFO. An optional repetition-count health test flags a stuck oscillator.

Parameters:
WORD_W, 32, output word width in bits (min 2)
DIV_W, 8, width of the sample-period control
REP_LIMIT, 32, consecutive identical samples that trip the health test (min 2)

Ports:
clk_i  input  1  block clock
rst_ni  input  1  asynchronous active-low reset
enable_i  input  1  sampling enable; low idles the block and clears partial state
raw_i  input  1  raw ring-oscillator tap, asynchronous to clk_i
div_i  input  DIV_W  sample period minus 1, in clk_i cycles
data_o  output  WORD_W  debiased entropy word
valid_o  output  1  data_o holds an unconsumed word
ready_i  input  1  consumer accepts data_o when high with valid_o
dropped_o  output  1  one-cycle pulse: a completed word was discarded due to backpressure
health_fail_o  output  1  sticky health-test failure (see Optional Feature)

Behaviour:
- Reset (rst_ni low, async): sync flops, divider, pair FSM, accumulator, bit count, data_o all 0; valid_o, dropped_o, health_fail_o 0.
- raw_i passes through a 2-flop synchronizer (reset 0). Only the second-flop output (samp) is used.
- Divider: while enable_i=1, cnt increments each cycle. When cnt==div_i, a strobe fires and cnt returns to 0. div_i=0 gives a strobe every cycle. div_i is sampled live; if cnt>div_i after a change, the strobe fires at wrap, not early.
- Pair FSM, states IDLE/FIRST/SECOND:
  - IDLE: enable_i=0; cnt=0. On enable_i=1 go to FIRST next cycle.
  - FIRST: on strobe, latch a=samp and go to SECOND.
  - SECOND: on strobe, b=samp. If a!=b, emit bit a. If a==b, discard the pair. Return to FIRST either way.
  - enable_i=0 in any state goes to IDLE next cycle. The latched a, the accumulator and the bit count are cleared. valid_o and data_o are retained until the handshake.
- Accumulator: acc <= {acc[WORD_W-2:0], bit} per emitted bit. The first emitted bit ends up in the MSB. Bit count runs 0..WORD_W-1.
- Word completion (emitted bit makes count WORD_W):
  - If valid_o=0, or valid_o&ready_i this cycle: data_o<=completed word, valid_o<=1 next cycle.
  - Else: the word is discarded, dropped_o=1 for exactly one cycle, and data_o/valid_o are unchanged.
  - Accumulator and count clear in all cases.
- Latency: valid_o rises the cycle after the completing strobe. raw_i to samp is 2 cycles.
- Handshake: valid_o&ready_i with no new word deasserts valid_o next cycle. data_o is stable while valid_o=1. ready_i while valid_o=0 is ignored.

Optional Feature:
Macro TRNG_HEALTH_EN.
- Defined: a repetition counter tracks consecutive identical samp values at strobes (both pair positions). It resets to 1 on change. On reaching REP_LIMIT, health_fail_o<=1.
- While health_fail_o=1, emitted bits are suppressed: no words complete, and the accumulator freezes.
- health_fail_o and the counter clear only on enable_i=0 or reset.
- Not defined: no counter logic; health_fail_o tied to 0.

Test Plan:
1. div_i=0, ready_i=1, samp sequence 1,0 repeated 32 pairs -> valid_o rises 1 cycle after the 64th strobe, data_o=0xFFFFFFFF. Then 0,1 x32 -> data_o=0x00000000.
2. Pairs 1,0 then 0,1 alternating, with 1,1 and 0,0 pairs interleaved -> discarded pairs add no bits; data_o=0xAAAAAAAA.
3. ready_i=0, two words completed -> dropped_o pulses once for 1 cycle at the 2nd completion. data_o keeps word 1. ready_i=1 then gives one handshake and valid_o falls.
4. div_i=3 -> strobes exactly every 4 cycles. A word completes after 256 cycles of clean pairs.
5. enable_i dropped after 10 bits while a word is pending -> pending word stays valid; re-enable gives the next word built from 32 fresh bits.
6. raw_i stuck at 1, TRNG_HEALTH_EN defined -> health_fail_o=1 after the 32nd strobe with no valid_o. Without the macro: health_fail_o stays 0 and no valid_o. Async rst_ni mid-word clears all outputs immediately.
